// File: rtl/game_controller.sv
// Tic-tac-toe move controller: validates moves, tracks both boards and the
// player to move, and detects wins and draws one cycle after each accepted move.
module game_controller #(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [8:0] square_sel,
    output logic       dec_en,
    output logic [8:0] x_board,
    output logic [8:0] o_board,
    output logic       turn,
    output logic [1:0] state,
    output logic [1:0] winner,
    output logic       done,
    output logic       illegal,
    output logic [3:0] move_cnt
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_CHECK = 2'b01,
        ST_OVER  = 2'b10
    } state_t;

    state_t     state_r, state_s;
    logic [8:0] x_r, x_s, o_r, o_s;
    logic       turn_r, turn_s;
    logic [1:0] winner_r, winner_s;
    logic [3:0] cnt_r, cnt_s;
    logic       illegal_r, illegal_s;
    logic       done_r;

    function automatic logic is_onehot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    // Any of the eight rows, columns or diagonals fully occupied.
    function automatic logic has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Next-state and next-register values; new_game overrides everything.
    always_comb begin
        x_s       = x_r;
        o_s       = o_r;
        turn_s    = turn_r;
        state_s   = state_r;
        winner_s  = winner_r;
        cnt_s     = cnt_r;
        illegal_s = 1'b0;
        case (state_r)
            ST_PLAY: begin
                if (move_valid) begin
                    if (is_onehot(square_sel) && ((square_sel & (x_r | o_r)) == 9'd0)) begin
                        if (turn_r) begin
                            o_s = o_r | square_sel;
                        end else begin
                            x_s = x_r | square_sel;
                        end
                        cnt_s   = cnt_r + 4'd1;
                        state_s = ST_CHECK;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    illegal_s = 1'b0;
                end
            end
            ST_CHECK: begin
                // Win is tested before the draw so a ninth-move line wins.
                if (has_line(turn_r ? o_r : x_r)) begin
                    winner_s = turn_r ? 2'b10 : 2'b01;
                    state_s  = ST_OVER;
                end else if (cnt_r == 4'd9) begin
                    winner_s = 2'b11;
                    state_s  = ST_OVER;
                end else begin
                    turn_s  = ~turn_r;
                    state_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                state_s = ST_OVER;
            end
            default: begin
                state_s = ST_PLAY;
            end
        endcase
        if (new_game) begin
            x_s       = 9'd0;
            o_s       = 9'd0;
            turn_s    = FIRST_PLAYER;
            state_s   = ST_PLAY;
            winner_s  = 2'b00;
            cnt_s     = 4'd0;
            illegal_s = 1'b0;
        end else begin
            illegal_s = illegal_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_PLAY;
            x_r       <= 9'd0;
            o_r       <= 9'd0;
            turn_r    <= FIRST_PLAYER;
            winner_r  <= 2'b00;
            cnt_r     <= 4'd0;
            illegal_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            x_r       <= x_s;
            o_r       <= o_s;
            turn_r    <= turn_s;
            winner_r  <= winner_s;
            cnt_r     <= cnt_s;
            illegal_r <= illegal_s;
            done_r    <= (state_s == ST_OVER);
        end
    end

    assign dec_en   = (state_r == ST_PLAY);
    assign x_board  = x_r;
    assign o_board  = o_r;
    assign turn     = turn_r;
    assign state    = state_r;
    assign winner   = winner_r;
    assign done     = done_r;
    assign illegal  = illegal_r;
    assign move_cnt = cnt_r;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: hand-computed boards, winners and
// illegal-move pulses, sampled on the falling clock edge.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [8:0] square_sel = 9'd0;
    logic       dec_en;
    logic [8:0] x_board, o_board;
    logic       turn;
    logic [1:0] state, winner;
    logic       done, illegal;
    logic [3:0] move_cnt;

    int errors = 0;
    int checks = 0;

    game_controller #(.FIRST_PLAYER(1'b0)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
        .square_sel(square_sel), .dec_en(dec_en), .x_board(x_board),
        .o_board(o_board), .turn(turn), .state(state), .winner(winner),
        .done(done), .illegal(illegal), .move_cnt(move_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepted move: strobe for one edge (PLAY->CHECK), then let CHECK resolve.
    task automatic play(input int sq);
        move_valid = 1'b1;
        square_sel = 9'd1 << sq;
        @(negedge clk);
        move_valid = 1'b0;
        square_sel = 9'd0;
        @(negedge clk);
    endtask

    task automatic ng();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_state", {7'd0, state}, 9'd0);
        chk("rst_dec_en", {8'd0, dec_en}, 9'd1);
        chk("rst_turn", {8'd0, turn}, 9'd0);
        chk("rst_x", x_board, 9'd0);
        chk("rst_o", o_board, 9'd0);
        chk("rst_winner", {7'd0, winner}, 9'd0);
        chk("rst_done", {8'd0, done}, 9'd0);
        chk("rst_illegal", {8'd0, illegal}, 9'd0);
        chk("rst_cnt", {5'd0, move_cnt}, 9'd0);

        // X wins on the top row; check the CHECK-cycle latency of move one.
        move_valid = 1'b1;
        square_sel = 9'b000000001;
        @(negedge clk);
        move_valid = 1'b0;
        square_sel = 9'd0;
        chk("m1_state_check", {7'd0, state}, 9'd1);
        chk("m1_dec_en", {8'd0, dec_en}, 9'd0);
        chk("m1_x", x_board, 9'h001);
        chk("m1_cnt", {5'd0, move_cnt}, 9'd1);
        chk("m1_turn_pre", {8'd0, turn}, 9'd0);
        @(negedge clk);
        chk("m1_turn_post", {8'd0, turn}, 9'd1);
        chk("m1_state_play", {7'd0, state}, 9'd0);
        play(3); play(1); play(4); play(2);
        chk("win_x", x_board, 9'b000000111);
        chk("win_o", o_board, 9'b000011000);
        chk("win_winner", {7'd0, winner}, 9'd1);
        chk("win_done", {8'd0, done}, 9'd1);
        chk("win_dec_en", {8'd0, dec_en}, 9'd0);
        chk("win_cnt", {5'd0, move_cnt}, 9'd5);
        chk("win_state", {7'd0, state}, 9'd2);
        chk("win_turn", {8'd0, turn}, 9'd0);

        // OVER ignores moves; new_game beats a simultaneous move.
        move_valid = 1'b1;
        square_sel = 9'h100;
        @(negedge clk);
        chk("over_x", x_board, 9'b000000111);
        chk("over_o", o_board, 9'b000011000);
        chk("over_illegal", {8'd0, illegal}, 9'd0);
        chk("over_cnt", {5'd0, move_cnt}, 9'd5);
        new_game = 1'b1;
        @(negedge clk);
        chk("ng_x", x_board, 9'd0);
        chk("ng_o", o_board, 9'd0);
        chk("ng_state", {7'd0, state}, 9'd0);
        chk("ng_cnt", {5'd0, move_cnt}, 9'd0);
        chk("ng_turn", {8'd0, turn}, 9'd0);
        chk("ng_winner", {7'd0, winner}, 9'd0);
        chk("ng_done", {8'd0, done}, 9'd0);
        @(negedge clk);
        chk("ng_hold_x", x_board, 9'd0);
        chk("ng_hold_cnt", {5'd0, move_cnt}, 9'd0);
        new_game = 1'b0;
        move_valid = 1'b0;
        square_sel = 9'd0;

        // Occupied square rejected with a one-cycle pulse.
        play(4);
        move_valid = 1'b1;
        square_sel = 9'h010;
        @(negedge clk);
        move_valid = 1'b0;
        square_sel = 9'd0;
        chk("occ_illegal", {8'd0, illegal}, 9'd1);
        chk("occ_o", o_board, 9'd0);
        chk("occ_turn", {8'd0, turn}, 9'd1);
        chk("occ_cnt", {5'd0, move_cnt}, 9'd1);
        chk("occ_state", {7'd0, state}, 9'd0);
        @(negedge clk);
        chk("occ_pulse_end", {8'd0, illegal}, 9'd0);
        play(8);
        chk("o8_o", o_board, 9'h100);
        chk("o8_cnt", {5'd0, move_cnt}, 9'd2);
        chk("o8_turn", {8'd0, turn}, 9'd0);

        // Zero and multi-hot selects.
        move_valid = 1'b1;
        square_sel = 9'd0;
        @(negedge clk);
        chk("zero_illegal", {8'd0, illegal}, 9'd1);
        square_sel = 9'b000000011;
        @(negedge clk);
        move_valid = 1'b0;
        square_sel = 9'd0;
        chk("multi_illegal", {8'd0, illegal}, 9'd1);
        chk("multi_x", x_board, 9'h010);
        chk("multi_cnt", {5'd0, move_cnt}, 9'd2);
        chk("multi_state", {7'd0, state}, 9'd0);
        @(negedge clk);
        chk("multi_pulse_end", {8'd0, illegal}, 9'd0);

        // Move held through the CHECK cycle is ignored there.
        move_valid = 1'b1;
        square_sel = 9'h001;
        @(negedge clk);
        square_sel = 9'h004;
        @(negedge clk);
        move_valid = 1'b0;
        square_sel = 9'd0;
        chk("chk_ign_x", x_board, 9'h011);
        chk("chk_ign_illegal", {8'd0, illegal}, 9'd0);
        chk("chk_ign_cnt", {5'd0, move_cnt}, 9'd3);

        // Full-board draw.
        ng();
        play(0); play(1); play(2); play(4); play(3);
        play(5); play(7); play(6); play(8);
        chk("draw_winner", {7'd0, winner}, 9'd3);
        chk("draw_cnt", {5'd0, move_cnt}, 9'd9);
        chk("draw_x", x_board, 9'h18D);
        chk("draw_o", o_board, 9'h072);
        chk("draw_done", {8'd0, done}, 9'd1);

        // Ninth move completes a line: win beats draw.
        ng();
        play(0); play(1); play(2); play(4); play(3);
        play(5); play(7); play(8); play(6);
        chk("win9_winner", {7'd0, winner}, 9'd1);
        chk("win9_cnt", {5'd0, move_cnt}, 9'd9);

        // Reset during the CHECK of a winning move discards the result.
        ng();
        play(0); play(3); play(1); play(4);
        move_valid = 1'b1;
        square_sel = 9'h004;
        @(negedge clk);
        move_valid = 1'b0;
        square_sel = 9'd0;
        chk("pre_rst_state", {7'd0, state}, 9'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstchk_winner", {7'd0, winner}, 9'd0);
        chk("rstchk_x", x_board, 9'd0);
        chk("rstchk_o", o_board, 9'd0);
        chk("rstchk_state", {7'd0, state}, 9'd0);
        chk("rstchk_turn", {8'd0, turn}, 9'd0);
        chk("rstchk_cnt", {5'd0, move_cnt}, 9'd0);
        @(negedge clk);
        chk("rstchk_hold_winner", {7'd0, winner}, 9'd0);
        chk("rstchk_hold_done", {8'd0, done}, 9'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter FIRST_PLAYER, default 0, SHALL select the player who moves first after reset/new game: 0 = X, 1 = O.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 new_game  input  1  level, sampled each edge; clears the game.
REQ-005 move_valid  input  1  single-cycle strobe: square_sel carries a move this cycle.
REQ-006 square_sel  input  9  move location, expected one-hot; bit 0 = top-left … bit 8 = bottom-right, row-major (row*3+col).
REQ-007 dec_en  output  1  enable to the row/col decoder; high only while moves are accepted.
REQ-008 x_board  output  9  registered X occupancy, same bit mapping as square_sel.
REQ-009 o_board  output  9  registered O occupancy, same bit mapping.
REQ-010 turn  output  1  player to move: 0 = X, 1 = O.
REQ-011 state  output  2  00 PLAY, 01 CHECK, 10 OVER; 11 unused.
REQ-012 winner  output  2  00 none, 01 X, 10 O, 11 draw.
REQ-013 done  output  1  high while state = OVER.
REQ-014 illegal  output  1  registered one-cycle pulse flagging a rejected move.
REQ-015 move_cnt  output  4  number of accepted moves, 0..9.

Function
REQ-016 All outputs SHALL be registered except dec_en, which SHALL be decoded combinationally from state (1 iff PLAY).
REQ-017 PLAY: on move_valid with square_sel exactly one-hot and (square_sel & (x_board|o_board)) == 0, the selected bit SHALL be set in the board of the player given by turn, move_cnt SHALL increment, and state SHALL go to CHECK at the same edge.
REQ-018 PLAY: on move_valid with square_sel zero, multi-hot, or occupied, boards, turn, move_cnt and state SHALL not change and illegal SHALL be 1 for exactly the next cycle.
REQ-019 PLAY without move_valid: all registers SHALL hold; illegal SHALL be 0.
REQ-020 CHECK (exactly one cycle): evaluate the board of turn against the 8 lines {0,1,2},{3,4,5},{6,7,8},{0,3,6},{1,4,7},{2,5,8},{0,4,8},{2,4,6}.
REQ-021 CHECK, line complete: winner SHALL become 01 (turn=0) or 10 (turn=1), state OVER, turn unchanged.
REQ-022 CHECK, no line, move_cnt = 9: winner SHALL become 11, state OVER.
REQ-023 CHECK, no line, move_cnt < 9: turn SHALL toggle, state PLAY.
REQ-024 Win SHALL take precedence over draw when the ninth move completes a line.
REQ-025 move_valid SHALL be ignored (no board change, no illegal pulse) in CHECK and OVER.
REQ-026 OVER: boards, winner, move_cnt, turn SHALL hold until new_game or rst.
REQ-027 Latency: accepted move strobed before edge N → board/move_cnt visible after N, state CHECK after N; winner/done/turn updated after N+1; next move accepted no earlier than the edge after N+1.
REQ-028 new_game = 1 in any state SHALL, at that edge, clear boards, move_cnt, winner, illegal, set turn = FIRST_PLAYER, state = PLAY; it SHALL take priority over a simultaneous move_valid.
REQ-029 Holding new_game high SHALL keep the block in the cleared PLAY state, accepting no moves.

Reset
REQ-030 rst SHALL have priority over all inputs and SHALL force: x_board = 0, o_board = 0, move_cnt = 0, winner = 00, illegal = 0, done = 0, state = PLAY (dec_en = 1), turn = FIRST_PLAYER.
REQ-031 rst asserted mid-CHECK or mid-OVER SHALL discard the pending evaluation with no winner update.

Verification
REQ-032 Reset, FIRST_PLAYER = 0; moves X:0, O:3, X:1, O:4, X:2 -> after last CHECK x_board = 000000111, o_board = 000011000, winner = 01, done = 1, dec_en = 0, move_cnt = 5.
REQ-033 X plays 4, then O plays 4 (occupied) -> illegal = 1 for one cycle, o_board = 0, turn stays 1, move_cnt = 1; O then plays 8 -> accepted.
REQ-034 move_valid with square_sel = 000000000 and again with 000000011 -> illegal pulse each, no state change.
REQ-035 Sequence X:0,O:1,X:2,O:4,X:3,O:5,X:7,O:6,X:8 -> winner = 11, move_cnt = 9; variant ending on line completion at move 9 -> winner = 01.
REQ-036 In OVER, move_valid with free square -> ignored; new_game together with move_valid -> boards 0, state PLAY, move_cnt 0, turn = FIRST_PLAYER.
REQ-037 rst asserted in CHECK cycle after a winning move -> winner = 00, boards 0, state PLAY next cycle.
